// File: rtl/srl_fifo_v2.sv
// srl_fifo_v2 -- shift-register FIFO with first-word fall-through.
//
// Words enter at entry 0 and every stored word moves up one entry on each
// push. The oldest word therefore sits at entry count-1, which is read
// combinationally, so no read-side register is needed.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; release must be synchronous to clk
//   flush        synchronous discard of all stored words (beats push/pop)
//   s_valid/s_ready/s_data   write handshake; s_ready low when full
//   m_valid/m_ready/m_data   read handshake; m_data = oldest word
//   count        occupancy 0..DEPTH
//   almost_full  count >= AFULL_LEVEL (registered)
//   max_count    occupancy high-water mark, cleared only by reset
//
// Parameter constraints: 2 <= DEPTH <= 2**ADDR_WIDTH.
module srl_fifo_v2 #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   max_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic [ADDR_WIDTH:0]   max_nxt;
    logic [ADDR_WIDTH-1:0] ptr;

    // s_ready/m_valid are registered copies of "not full"/"not empty", so
    // the handshakes never depend combinationally on the other side. A full
    // FIFO cannot accept in the same cycle it pops; the slot opens next cycle.
    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + ONE_C;
                2'b01:   count_nxt = count - ONE_C;
                default: count_nxt = count;
            endcase
        end
        max_nxt = (count_nxt > max_count) ? count_nxt : max_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            max_count   <= '0;
            s_ready     <= 1'b1;
            m_valid     <= 1'b0;
            almost_full <= (AFULL_C == '0);
        end else begin
            count       <= count_nxt;
            max_count   <= max_nxt;
            s_ready     <= (count_nxt < DEPTH_C);
            m_valid     <= (count_nxt != '0);
            almost_full <= (count_nxt >= AFULL_C);
        end
    end

    // Storage has no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[0] <= s_data;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // ptr wraps to all-ones when empty; m_data is don't-care then, the guard
    // only keeps the index inside the array when DEPTH < 2**ADDR_WIDTH.
    assign ptr = ADDR_WIDTH'(count - ONE_C);

    always_comb begin
        m_data = '0;
        if ({1'b0, ptr} < DEPTH_C) begin
            m_data = mem[ptr];
        end
    end

endmodule

// File: doc/srl_fifo_v2.md
SRL_FIFO_V2 -- requirements
Module: srl_fifo_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: width of the read pointer; DEPTH SHALL be at most 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 16: storage entries, minimum 2.
REQ-004 SHALL have parameter AFULL_LEVEL, default DEPTH-2: occupancy at or above which almost_full asserts.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  synchronous discard of all stored words.
REQ-008 SHALL have port s_valid  in  1  write request.
REQ-009 SHALL have port s_ready  out  1  write accepted when high (not full).
REQ-010 SHALL have port s_data  in  DATA_WIDTH  write word.
REQ-011 SHALL have port m_valid  out  1  read data available (not empty).
REQ-012 SHALL have port m_ready  in  1  read consume.
REQ-013 SHALL have port m_data  out  DATA_WIDTH  oldest stored word, first-word fall-through.
REQ-014 SHALL have port count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port almost_full  out  1  count >= AFULL_LEVEL.
REQ-016 SHALL have port max_count  out  ADDR_WIDTH+1  occupancy high-water mark.

Function
REQ-017 Storage SHALL be a DEPTH-entry shift chain: on push, every entry i moves to i+1 and s_data enters entry 0; entries SHALL have no reset.
REQ-018 A read pointer ptr SHALL equal count-1, and m_data SHALL be the combinational value of entry[ptr]; m_data is don't-care while m_valid is low.
REQ-019 push SHALL be s_valid && s_ready, and pop SHALL be m_valid && m_ready.
REQ-020 Push only: shift, count+1. Pop only: no shift, count-1. Push and pop in the same cycle: shift, count unchanged, and m_data SHALL present the next-oldest word after the edge.
REQ-021 s_ready, m_valid and almost_full SHALL be registered, derived from the next-state count: s_ready = next count < DEPTH, m_valid = next count > 0.
REQ-022 When full (count = DEPTH), s_ready SHALL be low, including in a cycle where pop is high; the freed slot becomes writable on the following cycle.
REQ-023 When empty, m_ready SHALL be ignored; a push into an empty FIFO SHALL raise m_valid one cycle later, giving a write-to-read latency of one cycle.
REQ-024 Push while s_ready is low, or pop while m_valid is low, SHALL leave all state unchanged.
REQ-025 flush high SHALL override push and pop in that cycle: next count = 0, m_valid = 0, s_ready = 1, almost_full = 0 (if AFULL_LEVEL > 0); max_count is kept.
REQ-026 max_count SHALL update each cycle to max(max_count, next count) and SHALL clear only on reset.
REQ-027 count SHALL never wrap: it stays within 0..DEPTH under every input combination.

Reset
REQ-028 Asserting reset SHALL immediately, without waiting for a clock edge, set count = 0, m_valid = 0, s_ready = 1, almost_full = 0 (for AFULL_LEVEL > 0), and max_count = 0.
REQ-029 Reset asserted mid-transfer SHALL discard every stored word; the first push after reset deasserts SHALL be the first word read.
REQ-030 Deassertion of reset SHALL be synchronised to clk externally; the block SHALL accept a push on the first edge after reset deasserts.

Verification
Bench parameters for REQ-031 to REQ-035: DEPTH=4, DATA_WIDTH=8, AFULL_LEVEL=3.
REQ-031 Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with m_ready=0 -> count 1,2,3,4; almost_full high from count 3; s_ready low after the 4th push; m_data = 0x11.
REQ-032 With the FIFO full, s_valid=1 (data 0x55) and m_ready=1 -> 0x11 popped, 0x55 rejected, count=3; the next cycle 0x55 is accepted, and the read order is 0x22, 0x33, 0x44, 0x55.
REQ-033 With count=2, push and pop together for 5 cycles -> count stays 2 and the output order matches the input order.
REQ-034 With the FIFO empty, m_ready=1 and a single push of 0xA5 -> m_valid rises one cycle later with m_data=0xA5 and is popped that cycle; count returns to 0 without going negative.
REQ-035 Fill to 3, then flush together with push -> count=0 and m_valid=0 next cycle, max_count=3; then assert reset asynchronously between edges -> max_count=0 and s_ready=1 at once.
